joy_dir_filter: RTL and testbench
=================================

# joy_dir_filter

Multi-channel joystick direction conditioner placed between the player input mux and the game core's active-low button inputs. It synchronises raw direction bits, debounces them against a clock-enable tick, and applies a runtime-selectable direction policy per channel: passthrough, last-pressed-wins 4-way, first-held-wins 4-way, or 8-way with opposite-direction cancel. It generalises the fixed 2-player one-direction masking used by the Lady Bug family to N channels, adds debounce, deterministic 4-way priority and change strobes.

## Interface
- CHANNELS, 2: number of independent joystick channels (1..8).
- DEBOUNCE, 4: consecutive ce_tick pulses a changed bit must persist before acceptance; 0 = no debounce.
- clk  in  1  system clock (clk_sys domain).
- reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- ce_tick  in  1  debounce sampling enable, one-cycle pulse.
- mode  in  2  policy: 0 passthrough, 1 last-pressed 4-way, 2 first-held 4-way, 3 8-way SOCD-neutral.
- dir_in  in  4*CHANNELS  active-high raw directions; channel c at [4c+3:4c], bit order {up,down,left,right}.
- dir_out  out  4*CHANNELS  active-high filtered directions, same packing.
- dir_chg  out  CHANNELS  one-cycle pulse when that channel's dir_out changes.

## Operation
- Per bit: 2-flop synchroniser (s1, s2) -> stable register -> policy -> registered dir_out.
- Debounce (DEBOUNCE>0): per-bit counter, width clog2(DEBOUNCE+1). s2 == stable: counter cleared. s2 != stable: counter increments on ce_tick; when incremented value reaches DEBOUNCE, stable <= s2 and counter clears. Bounce back before that clears counter. DEBOUNCE=0: stable <= s2 every clk.
- prev register holds last cycle's stable; rise = stable & ~prev.
- Priority function P(x): single highest-set bit, up > down > left > right; P(0)=0.
- Mode 0: dir_out <= stable.
- Mode 1: per-channel mask (4 bits). mask_n: if rise != 0 then P(rise) else mask; then if (stable & mask_n)==0, mask_n = 4'b1111. mask <= mask_n. dir_out <= (mask_n==4'b1111) ? P(stable) : stable & mask_n.
- Mode 2: per-channel latch L (one-hot or 0). If (stable & L)==0: L_n = P(stable), else L_n = L (new presses ignored while L held). dir_out <= L_n.
- Mode 3: up&down both held -> both cleared; left&right both held -> both cleared; diagonals pass.
- dir_chg[c] <= (next dir_out slice != current dir_out slice).
- Mode change (mode differs from previous cycle's mode): mask <= 4'b1111, L <= 0 for all channels that cycle; dir_out computed with the reset state under the new mode.
- Channels are fully independent; no cross-channel interaction.

## Timing
- Reset (async assert, sync-free deassert): s1, s2, stable, prev, counters, dir_out, dir_chg = 0; mask = 4'b1111; L = 0; mode history = 0.
- DEBOUNCE=0: dir_in change set up before edge 0 appears on dir_out after edge 3 (s1@0, s2@1, stable@2, dir_out@3); dir_chg high in the cycle following edge 3, for one cycle.
- DEBOUNCE>0: stable updates at the edge on which the DEBOUNCE-th ce_tick after s2 diverges is sampled; dir_out one edge later.
- Simultaneous rises in one cycle: P selects winner (up wins).
- ce_tick held high continuously: debounce counts every clk.
- reset_n asserted mid-debounce or mid-hold: all state cleared immediately; no dir_chg pulse on release of reset.

## Test plan
- Reset: reset_n=0 with dir_in=all 1s -> dir_out=0, dir_chg=0; after release, DEBOUNCE=0, mode 0, dir_out=all 1s after 4 edges, dir_chg=all 1s for one cycle.
- Debounce: DEBOUNCE=4, ce_tick every 8 clk; pulse right for 3 ticks -> no output change; hold 4 ticks -> right asserted one clk after 4th tick sampled.
- Mode 1: hold left, then add up -> out 4'b1000; release up -> out 4'b0010 (mask reset, P picks left); press up+right same cycle from idle -> 4'b1000.
- Mode 2: hold down, then add left -> out 4'b0100 stays; release down -> out 4'b0010.
- Mode 3: up+down+right -> 4'b0001; up+left -> 4'b1010; all four -> 0.
- Channel isolation and mode switch: CHANNELS=4, drive channel 2 only -> other slices and dir_chg bits stay 0; switch mode 1->2 while holding up+left -> mask/latch reset, out 4'b1000 next edge.

Source files
------------

// File: rtl/joy_dir_filter_if.sv
// joy_dir_filter bus: tick, policy select, raw and filtered directions.
// Direction nibbles are packed {up,down,left,right}, channel c at [4c+3:4c].
interface joy_dir_filter_if #(
    parameter int CHANNELS = 2
);
    logic                    ce_tick;
    logic [1:0]              mode;
    logic [4*CHANNELS-1:0]   dir_in;
    logic [4*CHANNELS-1:0]   dir_out;
    logic [CHANNELS-1:0]     dir_chg;

    modport master (
        output ce_tick,
        output mode,
        output dir_in,
        input  dir_out,
        input  dir_chg
    );

    modport slave (
        input  ce_tick,
        input  mode,
        input  dir_in,
        output dir_out,
        output dir_chg
    );
endinterface

// File: rtl/joy_dir_filter.sv
// Joystick direction conditioner: sync, tick debounce, per-channel policy.
// Policies: passthrough, last-pressed 4-way, first-held 4-way, 8-way SOCD.
module joy_dir_filter #(
    parameter int CHANNELS = 2,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    joy_dir_filter_if.slave  bus
);
    localparam int NB = 4 * CHANNELS;
    localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

    logic [NB-1:0] s1, s2, stable, prev, stable_n;
    logic [NB-1:0] out_q, out_d;
    logic [CW-1:0] cnt   [NB];
    logic [CW-1:0] cnt_n [NB];
    logic [3:0]    mask   [CHANNELS];
    logic [3:0]    mask_n [CHANNELS];
    logic [3:0]    lat    [CHANNELS];
    logic [3:0]    lat_n  [CHANNELS];
    logic [CHANNELS-1:0] chg_q, chg_d;
    logic [1:0]    mode_q;
    logic          mode_chg;

    function automatic logic [3:0] pri(input logic [3:0] x);
        logic [3:0] r;
        r = 4'b0000;
        priority case (1'b1)
            x[3]:    r = 4'b1000;
            x[2]:    r = 4'b0100;
            x[1]:    r = 4'b0010;
            x[0]:    r = 4'b0001;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    assign mode_chg = (bus.mode != mode_q);

    always_comb begin
        stable_n = stable;
        for (int i = 0; i < NB; i++) begin
            cnt_n[i] = '0;
            if (DEBOUNCE == 0) begin
                stable_n[i] = s2[i];
            end else if (s2[i] != stable[i]) begin
                if (!bus.ce_tick) begin
                    cnt_n[i] = cnt[i];
                end else if (int'(cnt[i]) + 1 == DEBOUNCE) begin
                    stable_n[i] = s2[i];
                end else begin
                    cnt_n[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        logic [3:0] st, rise, m_cur, l_cur, m, l, o;
        out_d = '0;
        chg_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            st    = stable[4*c +: 4];
            rise  = st & ~prev[4*c +: 4];
            // a mode switch evaluates the new policy from its idle state
            m_cur = mode_chg ? 4'b1111 : mask[c];
            l_cur = mode_chg ? 4'b0000 : lat[c];
            m     = (rise != 4'b0000) ? pri(rise) : m_cur;
            if ((st & m) == 4'b0000) m = 4'b1111;
            l     = ((st & l_cur) == 4'b0000) ? pri(st) : l_cur;
            mask_n[c] = mode_chg ? 4'b1111 : m;
            lat_n[c]  = mode_chg ? 4'b0000 : l;
            o = st;
            unique case (bus.mode)
                2'd0: o = st;
                2'd1: o = (m == 4'b1111) ? pri(st) : (st & m);
                2'd2: o = l;
                2'd3: begin
                    o = st;
                    if (st[3] && st[2]) o[3:2] = 2'b00;
                    if (st[1] && st[0]) o[1:0] = 2'b00;
                end
                default: o = st;
            endcase
            out_d[4*c +: 4] = o;
            chg_d[c]        = (o != out_q[4*c +: 4]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            prev   <= '0;
            out_q  <= '0;
            chg_q  <= '0;
            mode_q <= 2'd0;
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                mask[c] <= 4'b1111;
                lat[c]  <= 4'b0000;
            end
        end else begin
            s1     <= bus.dir_in;
            s2     <= s1;
            stable <= stable_n;
            prev   <= stable;
            out_q  <= out_d;
            chg_q  <= chg_d;
            mode_q <= bus.mode;
            for (int i = 0; i < NB; i++) cnt[i] <= cnt_n[i];
            for (int c = 0; c < CHANNELS; c++) begin
                mask[c] <= mask_n[c];
                lat[c]  <= lat_n[c];
            end
        end
    end

    assign bus.dir_out = out_q;
    assign bus.dir_chg = chg_q;
endmodule

// File: tb/tb_joy_dir_filter.sv
// Bench for joy_dir_filter: directed scenarios plus random traffic
// checked against a rule-level model of both instances.
module tb_joy_dir_filter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    joy_dir_filter_if #(.CHANNELS(4)) if0();
    joy_dir_filter_if #(.CHANNELS(2)) if1();

    joy_dir_filter #(.CHANNELS(4), .DEBOUNCE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0));
    joy_dir_filter #(.CHANNELS(2), .DEBOUNCE(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1));

    int passed = 0;
    int total  = 0;
    int nprint = 0;
    int div    = 0;
    int ticks  = 0;

    localparam int DB [2] = '{0, 4};

    logic [3:0] din_a [2][4];
    logic [1:0] md_a  [2];
    logic       ce_a  [2];

    logic [3:0] m_s1 [2][4], m_s2 [2][4], m_st [2][4], m_pv [2][4];
    logic [3:0] m_mk [2][4], m_lt [2][4], m_out [2][4];
    logic       m_chg [2][4];
    int         m_cnt [2][4][4];
    logic [1:0] m_md [2];

    function automatic logic [3:0] win(input logic [3:0] x);
        logic [3:0] r = 4'b0000;
        for (int b = 0; b < 4; b++) if (x[b]) r = 4'b0001 << b;
        return r;
    endfunction

    function automatic logic [3:0] mk_next(input logic [3:0] st, pv, mk);
        logic [3:0] r;
        r = ((st & ~pv) != 0) ? win(st & ~pv) : mk;
        if ((st & r) == 0) r = 4'b1111;
        return r;
    endfunction

    function automatic logic [3:0] lt_next(input logic [3:0] st, lt);
        return ((st & lt) == 0) ? win(st) : lt;
    endfunction

    function automatic logic [3:0] policy(input logic [1:0] md,
                                          input logic [3:0] st, pv, mk, lt);
        logic [3:0] r;
        case (md)
            2'd0: r = st;
            2'd1: begin
                r = mk_next(st, pv, mk);
                r = (r == 4'b1111) ? win(st) : (st & r);
            end
            2'd2: r = lt_next(st, lt);
            default: begin
                r = st;
                if (st[3] && st[2]) r = r & 4'b0011;
                if (st[1] && st[0]) r = r & 4'b1100;
            end
        endcase
        return r;
    endfunction

    function automatic logic deb_st(input int d, input logic s2, st,
                                    input int cnt, input logic ce);
        if (d == 0) return s2;
        if (s2 != st && ce && cnt + 1 >= d) return s2;
        return st;
    endfunction

    function automatic int deb_cnt(input int d, input logic s2, st,
                                   input int cnt, input logic ce);
        if (d == 0 || s2 == st) return 0;
        if (!ce) return cnt;
        if (cnt + 1 >= d) return 0;
        return cnt + 1;
    endfunction

    always_comb begin
        for (int u = 0; u < 2; u++)
            for (int c = 0; c < 4; c++) din_a[u][c] = 4'b0000;
        for (int c = 0; c < 4; c++) din_a[0][c] = if0.dir_in[4*c +: 4];
        for (int c = 0; c < 2; c++) din_a[1][c] = if1.dir_in[4*c +: 4];
        md_a[0] = if0.mode;
        md_a[1] = if1.mode;
        ce_a[0] = if0.ce_tick;
        ce_a[1] = if1.ce_tick;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int u = 0; u < 2; u++) begin
                m_md[u] <= 2'd0;
                for (int c = 0; c < 4; c++) begin
                    m_s1[u][c] <= 0; m_s2[u][c] <= 0;
                    m_st[u][c] <= 0; m_pv[u][c] <= 0;
                    m_mk[u][c] <= 4'b1111; m_lt[u][c] <= 0;
                    m_out[u][c] <= 0; m_chg[u][c] <= 0;
                    for (int b = 0; b < 4; b++) m_cnt[u][c][b] <= 0;
                end
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                m_md[u] <= md_a[u];
                for (int c = 0; c < 4; c++) begin
                    m_s1[u][c] <= din_a[u][c];
                    m_s2[u][c] <= m_s1[u][c];
                    m_pv[u][c] <= m_st[u][c];
                    for (int b = 0; b < 4; b++) begin
                        m_st[u][c][b] <= deb_st(DB[u], m_s2[u][c][b],
                            m_st[u][c][b], m_cnt[u][c][b], ce_a[u]);
                        m_cnt[u][c][b] <= deb_cnt(DB[u], m_s2[u][c][b],
                            m_st[u][c][b], m_cnt[u][c][b], ce_a[u]);
                    end
                    if (md_a[u] != m_md[u]) begin
                        m_mk[u][c] <= 4'b1111;
                        m_lt[u][c] <= 4'b0000;
                        m_out[u][c] <= policy(md_a[u], m_st[u][c],
                            m_pv[u][c], 4'b1111, 4'b0000);
                        m_chg[u][c] <= policy(md_a[u], m_st[u][c],
                            m_pv[u][c], 4'b1111, 4'b0000) != m_out[u][c];
                    end else begin
                        m_mk[u][c] <= mk_next(m_st[u][c], m_pv[u][c],
                                              m_mk[u][c]);
                        m_lt[u][c] <= lt_next(m_st[u][c], m_lt[u][c]);
                        m_out[u][c] <= policy(md_a[u], m_st[u][c],
                            m_pv[u][c], m_mk[u][c], m_lt[u][c]);
                        m_chg[u][c] <= policy(md_a[u], m_st[u][c],
                            m_pv[u][c], m_mk[u][c], m_lt[u][c]) != m_out[u][c];
                    end
                end
            end
        end
    end

    task automatic clk1();
        if1.ce_tick = (div == 7);
        if (div == 7) ticks++;
        div = (div + 1) % 8;
        if0.ce_tick = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) clk1();
    endtask

    task automatic put0(input int ch, input logic [3:0] v);
        if0.dir_in = 16'(v) << (4 * ch);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        if0.dir_in = '1; if0.mode = 2'd0; if0.ce_tick = 1'b0;
        if1.dir_in = '0; if1.mode = 2'd0; if1.ce_tick = 1'b0;
        @(negedge clk); @(negedge clk);
        total++;
        if (if0.dir_out !== 16'h0) $display("FAIL rst_out0 got %h want 0000", if0.dir_out);
        else passed++;
        total++;
        if (if0.dir_chg !== 4'h0) $display("FAIL rst_chg0 got %h want 0", if0.dir_chg);
        else passed++;
        total++;
        if (if1.dir_out !== 8'h0) $display("FAIL rst_out1 got %h want 00", if1.dir_out);
        else passed++;
        reset_n = 1'b1;
        settle(3);
        total++;
        if (if0.dir_out !== 16'h0 || if0.dir_chg !== 4'h0)
            $display("FAIL rel_e2 got %h/%h want 0000/0", if0.dir_out, if0.dir_chg);
        else passed++;
        clk1();
        total++;
        if (if0.dir_out !== 16'hFFFF) $display("FAIL rel_e3_out got %h want ffff", if0.dir_out);
        else passed++;
        total++;
        if (if0.dir_chg !== 4'hF) $display("FAIL rel_e3_chg got %h want f", if0.dir_chg);
        else passed++;
        clk1();
        total++;
        if (if0.dir_chg !== 4'h0 || if0.dir_out !== 16'hFFFF)
            $display("FAIL rel_e4 got %h/%h want ffff/0", if0.dir_out, if0.dir_chg);
        else passed++;
    endtask

    task automatic test_debounce();
        logic bad = 1'b0;
        while (div != 0) clk1();
        if1.dir_in = 8'h01;
        ticks = 0;
        while (ticks < 3) begin
            clk1();
            if (if1.dir_out !== 8'h00) bad = 1'b1;
        end
        if1.dir_in = 8'h00;
        repeat (12) begin
            clk1();
            if (if1.dir_out !== 8'h00 || if1.dir_chg !== 2'b00) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL deb_pulse got change want none");
        else passed++;
        while (div != 0) clk1();
        if1.dir_in = 8'h01;
        ticks = 0;
        while (ticks < 4) clk1();
        total++;
        if (if1.dir_out !== 8'h00) $display("FAIL deb_early got %h want 00", if1.dir_out);
        else passed++;
        clk1();
        total++;
        if (if1.dir_out !== 8'h01 || if1.dir_chg !== 2'b01)
            $display("FAIL deb_hold got %h/%b want 01/01", if1.dir_out, if1.dir_chg);
        else passed++;
        if1.dir_in = 8'h00;
        settle(40);
    endtask

    task automatic step_chk(input string nm, input int ch,
                            input logic [3:0] v, input logic [3:0] exp);
        put0(ch, v);
        settle(4);
        total++;
        if (if0.dir_out[4*ch +: 4] !== exp)
            $display("FAIL %s got %b want %b", nm, if0.dir_out[4*ch +: 4], exp);
        else passed++;
    endtask

    task automatic test_mode1();
        if0.dir_in = '0; if0.mode = 2'd1;
        settle(4);
        step_chk("m1_left",    1, 4'b0010, 4'b0010);
        step_chk("m1_add_up",  1, 4'b1010, 4'b1000);
        step_chk("m1_rel_up",  1, 4'b0010, 4'b0010);
        step_chk("m1_idle",    1, 4'b0000, 4'b0000);
        step_chk("m1_up_rt",   1, 4'b1001, 4'b1000);
    endtask

    task automatic test_mode2();
        if0.dir_in = '0; if0.mode = 2'd2;
        settle(4);
        step_chk("m2_down",    3, 4'b0100, 4'b0100);
        step_chk("m2_add_lt",  3, 4'b0110, 4'b0100);
        step_chk("m2_rel_dn",  3, 4'b0010, 4'b0010);
    endtask

    task automatic test_mode3();
        if0.dir_in = '0; if0.mode = 2'd3;
        settle(4);
        step_chk("m3_ud_r",    0, 4'b1101, 4'b0001);
        step_chk("m3_diag",    0, 4'b1010, 4'b1010);
        step_chk("m3_all",     0, 4'b1111, 4'b0000);
    endtask

    task automatic test_isolation();
        logic bad = 1'b0;
        if0.dir_in = '0; if0.mode = 2'd0;
        settle(4);
        repeat (30) begin
            if0.dir_in[11:8] = 4'($urandom);
            clk1();
            if ((if0.dir_out & 16'hF0FF) !== 16'h0 ||
                (if0.dir_chg & 4'b1011) !== 4'h0) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL iso got activity on idle channels want none");
        else passed++;
        if0.mode = 2'd1;
        step_chk("sw_up",      2, 4'b1000, 4'b1000);
        step_chk("sw_add_lt",  2, 4'b1010, 4'b0010);
        if0.mode = 2'd2;
        clk1();
        total++;
        if (if0.dir_out[11:8] !== 4'b1000 || if0.dir_chg[2] !== 1'b1)
            $display("FAIL sw_m2 got %b/%b want 1000/1",
                     if0.dir_out[11:8], if0.dir_chg[2]);
        else passed++;
    endtask

    task automatic cmp_model(input string nm);
        logic [15:0] e0;
        logic [3:0]  c0;
        logic [7:0]  e1;
        logic [1:0]  c1;
        for (int c = 0; c < 4; c++) begin
            e0[4*c +: 4] = m_out[0][c];
            c0[c] = m_chg[0][c];
        end
        for (int c = 0; c < 2; c++) begin
            e1[4*c +: 4] = m_out[1][c];
            c1[c] = m_chg[1][c];
        end
        total++;
        if (if0.dir_out !== e0 || if0.dir_chg !== c0) begin
            if (nprint < 10)
                $display("FAIL %s_u0 got %h/%h want %h/%h", nm,
                         if0.dir_out, if0.dir_chg, e0, c0);
            nprint++;
        end else passed++;
        total++;
        if (if1.dir_out !== e1 || if1.dir_chg !== c1) begin
            if (nprint < 10)
                $display("FAIL %s_u1 got %h/%h want %h/%h", nm,
                         if1.dir_out, if1.dir_chg, e1, c1);
            nprint++;
        end else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) if0.dir_in = 16'($urandom);
            if ($urandom_range(0, 39) == 0) if1.dir_in = 8'($urandom);
            if ($urandom_range(0, 49) == 0) if0.mode = 2'($urandom);
            if ($urandom_range(0, 49) == 0) if1.mode = 2'($urandom);
            clk1();
            cmp_model("rand");
        end
    endtask

    task automatic test_reset_mid();
        if1.dir_in = 8'hFF;
        settle(20);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (if0.dir_out !== 16'h0 || if1.dir_out !== 8'h0 ||
            if0.dir_chg !== 4'h0 || if1.dir_chg !== 2'h0)
            $display("FAIL mid_rst got %h/%h want 0/0", if0.dir_out, if1.dir_out);
        else passed++;
        if0.dir_in = '0; if1.dir_in = '0;
        @(negedge clk);
        reset_n = 1'b1;
        settle(5);
        total++;
        if (if0.dir_chg !== 4'h0 || if1.dir_chg !== 2'h0 ||
            if0.dir_out !== 16'h0 || if1.dir_out !== 8'h0)
            $display("FAIL post_rst got %h/%h want 0/0", if0.dir_chg, if1.dir_chg);
        else passed++;
        cmp_model("post_rst");
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_mode1();
        test_mode2();
        test_mode3();
        test_isolation();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
